// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter moving whole frames from N_REQ payload FIFOs to one encapsulator, with IFG and MAX_LEN truncation.
// Latency: pop to read_en/data_in is one clock; a frame waits in OFFER until data_recive, and the next one waits for tx_busy to fall plus the IFG.
module tx_frame_arbiter #(
  parameter int N_REQ      = 4,
  parameter int IFG_CYCLES = 12,
  parameter int MAX_LEN    = 1500
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     src_req,
  input  logic [N_REQ-1:0]     src_empty,
  input  logic [8*N_REQ-1:0]   src_data,
  output logic [N_REQ-1:0]     src_rd,
  output logic [7:0]           data_in,
  output logic                 read_en,
  output logic                 buffer_ready,
  output logic                 buffer_empt,
  input  logic                 data_recive,
  input  logic                 tx_busy,
  output logic [N_REQ-1:0]     grant,
  output logic                 trunc_err
);

  localparam int SW = $clog2(N_REQ);
  localparam int IW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [IW-1:0] IFG_LAST = IW'(IFG_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, OFFER, XFER, DONE, WAIT_TX, IFG} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sel_q, rr_ptr_q, pick;
  logic [15:0]     byte_cnt_q;
  logic [IW-1:0]   ifg_cnt_q;
  logic            trunc_q, busy_seen_q;
  logic            found, any_req, cur_empty, at_max, xfer_pop, drain_pop;
  logic [7:0]      cur_data;
  logic [N_REQ-1:0] sel_oh;
  int              j;

  assign any_req   = |src_req;
  assign cur_empty = src_empty[sel_q];
  assign cur_data  = src_data[{sel_q, 3'b000} +: 8];
  assign at_max    = (byte_cnt_q == 16'(MAX_LEN));
  assign sel_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << sel_q;

  // Forwarded pops in XFER; after a truncation the tail is drained during IFG and dropped.
  assign xfer_pop  = (state_q == XFER) && !cur_empty && !at_max;
  assign drain_pop = (state_q == IFG) && trunc_q && !cur_empty;

  always_comb begin
    pick  = rr_ptr_q;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && src_req[j]) begin
        pick  = SW'(j);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    src_rd       = '0;
    grant        = '0;
    buffer_ready = 1'b0;
    buffer_empt  = 1'b0;
    trunc_err    = 1'b0;
    if (xfer_pop || drain_pop) src_rd = sel_oh;
    if (state_q != IDLE) grant = sel_oh;
    case (state_q)
      IDLE:    if (any_req) state_d = OFFER;
      OFFER: begin
        buffer_ready = 1'b1;
        if (data_recive) state_d = XFER;
      end
      XFER:    if (cur_empty || at_max) state_d = DONE;
      DONE: begin
        buffer_empt = 1'b1;
        trunc_err   = trunc_q;
        state_d     = WAIT_TX;
      end
      WAIT_TX: if (busy_seen_q && !tx_busy) state_d = IFG;
      IFG:     if ((ifg_cnt_q == IFG_LAST) && (!trunc_q || cur_empty)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      byte_cnt_q  <= '0;
      ifg_cnt_q   <= '0;
      trunc_q     <= 1'b0;
      busy_seen_q <= 1'b0;
      read_en     <= 1'b0;
      data_in     <= '0;
    end else begin
      state_q <= state_d;
      read_en <= xfer_pop;
      data_in <= cur_data;
      case (state_q)
        IDLE: if (any_req) begin
          sel_q      <= pick;
          rr_ptr_q   <= (pick == SW'(N_REQ - 1)) ? '0 : pick + 1'b1;
          byte_cnt_q <= '0;
          trunc_q    <= 1'b0;
        end
        XFER: begin
          if (xfer_pop) byte_cnt_q <= byte_cnt_q + 16'd1;
          if (at_max && !cur_empty) trunc_q <= 1'b1;
        end
        DONE:    busy_seen_q <= 1'b0;
        WAIT_TX: begin
          ifg_cnt_q <= '0;
          if (tx_busy) busy_seen_q <= 1'b1;
        end
        IFG:     if (ifg_cnt_q != IFG_LAST) ifg_cnt_q <= ifg_cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: FIFO + encapsulator models, byte/grant scoreboard.
module tb_tx_frame_arbiter;
  localparam int N   = 4;
  localparam int ML  = 64;
  localparam int IFG = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   src_req, src_empty, src_rd, grant;
  logic [8*N-1:0] src_data;
  logic [7:0]     data_in;
  logic           read_en, buffer_ready, buffer_empt, data_recive, tx_busy, trunc_err;

  tx_frame_arbiter #(.N_REQ(N), .IFG_CYCLES(IFG), .MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst), .src_req(src_req), .src_empty(src_empty), .src_data(src_data),
    .src_rd(src_rd), .data_in(data_in), .read_en(read_en), .buffer_ready(buffer_ready),
    .buffer_empt(buffer_empt), .data_recive(data_recive), .tx_busy(tx_busy),
    .grant(grant), .trunc_err(trunc_err)
  );

  always #5 clk = ~clk;

  logic [7:0] fq [N][$];
  int         fl [N][$];
  logic [7:0] cur [$];
  logic [7:0] exp_dat [$];
  int         exp_gnt [$];
  int  cur_i = 0, cyc = 0, frames_done = 0, viol = 0;
  bit  loaded = 0, pend_pop = 0;
  int  n_rden = 0, n_empt = 0, n_trunc = 0, n_pops = 0;
  int  last_rden = 0, last_empt = 0, last_trunc = 0, last_pops = 0;
  int  fall_cyc = 0, last_gap = 0, recv_cyc = 0, last_empt_gap = 0;
  int  recv_delay = 2, busy_hold = 5;
  int  vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic add_frame(input int i, input int len, input bit ramp);
    for (int b = 0; b < len; b++) fq[i].push_back(ramp ? 8'(b) : 8'($urandom));
    fl[i].push_back(len);
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (frames_done < n && t < 20000) begin
      @(negedge clk); #2; t++;
    end
    if (frames_done < n) chk("frame_timeout", frames_done, n);
  endtask

  initial forever begin
    @(posedge clk); cyc++;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // FIFO model and output monitor.
  initial begin : env
    int gi, len;
    src_req = '0; src_empty = '1; src_data = '0;
    forever begin
      @(negedge clk);
      if (pend_pop) begin
        if (cur.size() > 0) cur.delete(0); else viol++;
        n_pops++;
        pend_pop = 0;
      end
      if (read_en) begin
        n_rden++;
        if (exp_dat.size() == 0) chk("extra_read_en", 1, 0);
        else chk("data_in", data_in, exp_dat.pop_front());
      end
      if (buffer_empt) begin
        n_empt++;
        last_empt_gap = cyc - recv_cyc;
      end
      if (trunc_err) n_trunc++;
      if (loaded && grant == '0) begin
        last_rden = n_rden; last_empt = n_empt; last_trunc = n_trunc; last_pops = n_pops;
        frames_done++;
        loaded = 0;
        cur.delete();
      end
      if (buffer_ready && !loaded) begin
        gi = -1;
        for (int k = 0; k < N; k++) if (grant == (4'(1) << k)) gi = k;
        if (exp_gnt.size() == 0) chk("unexpected_grant", grant, 0);
        else chk("grant", gi, exp_gnt.pop_front());
        if (gi >= 0 && fl[gi].size() > 0) begin
          len = fl[gi].pop_front();
          for (int b = 0; b < len; b++) cur.push_back(fq[gi].pop_front());
          for (int b = 0; b < len && b < ML; b++) exp_dat.push_back(cur[b]);
          cur_i = gi; loaded = 1;
          n_rden = 0; n_empt = 0; n_trunc = 0; n_pops = 0;
          last_gap = cyc - (fall_cyc + 1);
        end else chk("grant_valid", grant, 0);
      end
      for (int i = 0; i < N; i++) begin
        src_req[i]   = (fl[i].size() > 0);
        src_empty[i] = !(loaded && cur_i == i && cur.size() > 0);
        src_data[8*i +: 8] = (!src_empty[i]) ? cur[0] : 8'h00;
      end
      #1;
      if ((src_rd & ~grant) != '0) viol++;
      if (src_rd != '0 && (!loaded || cur.size() == 0)) viol++;
      pend_pop = loaded && src_rd[cur_i];
    end
  end

  // Encapsulator model: accept after recv_delay, stay busy until busy_hold cycles past buffer_empt.
  initial begin : encap
    int t;
    data_recive = 0; tx_busy = 0;
    forever begin
      @(negedge clk);
      if (rst && buffer_ready) begin
        repeat (recv_delay - 1) @(negedge clk);
        data_recive = 1; recv_cyc = cyc + 1;
        @(negedge clk);
        data_recive = 0; tx_busy = 1;
        t = 0;
        while (!buffer_empt && rst && t < 5000) begin
          @(negedge clk); t++;
        end
        if (t >= 5000) chk("buffer_empt_timeout", 0, 1);
        if (rst) repeat (busy_hold) @(negedge clk);
        tx_busy = 0; fall_cyc = cyc;
      end
    end
  end

  initial begin : main
    int base, t;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {src_rd, data_in, read_en, buffer_ready, buffer_empt, grant, trunc_err}, 0);
    @(negedge clk); rst = 1;

    // single 60-byte ramp frame from requester 1
    add_frame(1, 60, 1); exp_gnt.push_back(1);
    wait_frames(1);
    chk("single_rden", last_rden, 60);
    chk("single_empt", last_empt, 1);
    chk("single_trunc", last_trunc, 0);
    chk("single_drain", last_pops - last_rden, 0);

    // round robin from a fresh reset, all four requesters with three frames
    @(negedge clk); rst = 0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++) begin
        add_frame(i, 2 + i + f, 0);
        exp_gnt.push_back(i);
      end
    recv_delay = 1;
    @(negedge clk); @(negedge clk); rst = 1;
    base = frames_done;
    wait_frames(base + 12);
    chk("rr_last_rden", last_rden, 7);

    // inter-frame gap after a long tx_busy
    busy_hold = 100; recv_delay = 2;
    add_frame(0, 10, 0); add_frame(0, 5, 0);
    exp_gnt.push_back(0); exp_gnt.push_back(0);
    base = frames_done;
    wait_frames(base + 2);
    chk("ifg_gap", last_gap, IFG + 1);
    busy_hold = 5;

    // truncation at MAX_LEN, then an exactly MAX_LEN frame
    add_frame(2, ML + 4, 1); add_frame(2, ML, 0);
    exp_gnt.push_back(2); exp_gnt.push_back(2);
    base = frames_done;
    wait_frames(base + 1);
    chk("trunc_rden", last_rden, ML);
    chk("trunc_pulse", last_trunc, 1);
    chk("trunc_drain", last_pops - last_rden, 4);
    chk("trunc_empt", last_empt, 1);
    wait_frames(base + 2);
    chk("maxlen_rden", last_rden, ML);
    chk("maxlen_trunc", last_trunc, 0);
    chk("maxlen_drain", last_pops - last_rden, 0);

    // empty frame
    add_frame(3, 0, 0); exp_gnt.push_back(3);
    base = frames_done;
    wait_frames(base + 1);
    chk("empty_rden", last_rden, 0);
    chk("empty_empt", last_empt, 1);
    chk("empty_empt_delay", last_empt_gap, 1);

    // reset at byte 10, then lowest active requester wins
    add_frame(2, 40, 1); exp_gnt.push_back(2);
    base = frames_done;
    t = 0;
    while (!(loaded && n_rden == 10) && t < 5000) begin
      @(negedge clk); #2; t++;
    end
    chk("reset_reach_byte10", n_rden, 10);
    add_frame(1, 5, 0); add_frame(3, 5, 0);
    rst = 0;
    #1;
    chk("midframe_reset_outputs", {src_rd, data_in, read_en, buffer_ready, buffer_empt, grant, trunc_err}, 0);
    exp_dat.delete(); exp_gnt.delete();
    exp_gnt.push_back(1); exp_gnt.push_back(3);
    @(negedge clk); @(negedge clk); rst = 1;
    wait_frames(base + 3);
    chk("post_reset_rden", last_rden, 5);

    repeat (5) @(negedge clk);
    chk("src_rd_violations", viol, 0);
    chk("exp_dat_left", exp_dat.size(), 0);
    chk("exp_gnt_left", exp_gnt.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tx_frame_arbiter.md
TX_FRAME_ARBITER -- requirements
Module: tx_frame_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of payload FIFO requesters, range 2..8.
REQ-002 Parameter IFG_CYCLES, default 12: idle clocks enforced between frames, minimum 1.
REQ-003 Parameter MAX_LEN, default 1500: maximum payload bytes forwarded per frame.
REQ-004 Port clk  in  1: single clock; all logic is rising-edge.
REQ-005 Port rst  in  1: asynchronous, active-low reset.
REQ-006 Port src_req  in  N_REQ: bit i high means FIFO i holds at least one complete frame.
REQ-007 Port src_empty  in  N_REQ: bit i high means FIFO i has no bytes left in the current frame.
REQ-008 Port src_data  in  8*N_REQ: show-ahead head byte of FIFO i, in bits [8i+7:8i].
REQ-009 Port src_rd  out  N_REQ: one-hot pop strobe to the granted FIFO.
REQ-010 Port data_in  out  8: payload byte to the encapsulator.
REQ-011 Port read_en  out  1: data_in is valid this cycle.
REQ-012 Port buffer_ready  out  1: frame offered to the encapsulator.
REQ-013 Port buffer_empt  out  1: end of payload for the current frame.
REQ-014 Port data_recive  in  1: encapsulator accepts the offered frame.
REQ-015 Port tx_busy  in  1: encapsulator is framing or transmitting (not IDLE).
REQ-016 Port grant  out  N_REQ: one-hot owner of the datapath; zero in IDLE.
REQ-017 Port trunc_err  out  1: one-cycle pulse when a frame is cut at MAX_LEN.

Function
REQ-018 The FSM SHALL have the states IDLE, OFFER, XFER, DONE, WAIT_TX and IFG.
- IDLE -> OFFER: any src_req bit is set.
- OFFER -> XFER: data_recive = 1.
- XFER -> DONE: src_empty[sel] = 1 or byte_cnt = MAX_LEN.
- DONE -> WAIT_TX: after one cycle.
- WAIT_TX -> IFG: tx_busy has been seen high and is now low.
- IFG -> IDLE: ifg_cnt = IFG_CYCLES-1.
REQ-019 Arbitration SHALL be round-robin: on IDLE->OFFER, select the first set src_req bit at or after rr_ptr, wrapping from N_REQ-1 to 0.
REQ-020 On IDLE->OFFER, rr_ptr SHALL load sel+1 modulo N_REQ; sel and grant SHALL stay fixed until the FSM returns to IDLE.
REQ-021 In IDLE, src_req changes SHALL NOT affect grant; requests arriving in other states are held until IDLE.
REQ-022 buffer_ready SHALL be high throughout OFFER and low in all other states.
REQ-023 In XFER, each cycle with src_empty[sel] = 0 and byte_cnt < MAX_LEN SHALL:
- assert src_rd[sel] combinationally;
- increment byte_cnt (16-bit, cleared on OFFER entry).
REQ-024 read_en and data_in SHALL be registered: read_en(t+1) = src_rd[sel](t) and data_in(t+1) = src_data[sel](t); latency is one clock.
REQ-025 buffer_empt SHALL pulse for exactly one cycle in DONE, which is after the final read_en.
REQ-026 If byte_cnt reaches MAX_LEN while src_empty[sel] = 0, the arbiter SHALL:
- pulse trunc_err in DONE;
- in IFG, pop remaining bytes with src_rd[sel] until src_empty[sel]; those bytes are not forwarded.
- The IFG exit SHALL also require src_empty[sel] = 1.
REQ-027 A frame with src_empty[sel] = 1 on XFER entry SHALL go straight to DONE with zero read_en pulses.
REQ-028 If tx_busy is already high on WAIT_TX entry, that high SHALL count as seen.
REQ-029 src_rd SHALL never be asserted while src_empty[sel] = 1, and never to a non-granted index.

Reset
REQ-030 On rst low, the block SHALL asynchronously go to state = IDLE.
REQ-031 On rst low, all of these SHALL clear to 0: rr_ptr, sel, byte_cnt, ifg_cnt, src_rd, data_in, read_en, buffer_ready, buffer_empt, grant, trunc_err.
REQ-032 Reset mid-frame SHALL abandon the frame with no buffer_empt pulse; the FIFO contents are not flushed.
REQ-033 On rst release, the first grant SHALL go to the lowest-indexed active requester.

Verification
REQ-034 Single frame: src_req = 4'b0010, 60 bytes 0x00..0x3B, data_recive 2 cycles after buffer_ready -> grant = 4'b0010, 60 read_en pulses carrying 0x00..0x3B in order, one buffer_empt pulse.
REQ-035 Round-robin: all four requesters active, each with 3 frames -> grant order 0,1,2,3,0,1,2,3,0,1,2,3.
REQ-036 IFG: tx_busy high for 100 cycles, then low -> next buffer_ready exactly IFG_CYCLES+1 cycles after tx_busy falls.
REQ-037 Truncation: MAX_LEN = 16, 20-byte frame -> 16 read_en pulses, trunc_err pulses once, and 4 extra src_rd with no read_en before IDLE.
REQ-038 Empty frame: src_empty[sel] = 1 at XFER entry -> 0 read_en pulses, buffer_empt pulses 1 cycle after XFER entry.
REQ-039 Reset: rst low at byte 10 of XFER -> all outputs 0 that same cycle; after release, the next frame is granted to the lowest active requester.
